// File: rtl/alu_exec_pipe_if.sv
// Request/response bundle for the two-stage ALU execute pipe.
// The slave modport is the pipe's view; the master modport drives requests and consumes results.
interface alu_exec_pipe_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_res;
    logic         out_zero;
    logic         out_neg;
    logic         out_carry;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_zero, out_neg, out_carry
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_zero, out_neg, out_carry
    );
endinterface

// File: rtl/alu_exec_pipe.sv
// Two-stage execute pipe: stage 1 registers operands and feeds the ALU units,
// stage 2 registers the selected result and flags for the downstream handshake.
module alu_exec_pipe #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_exec_pipe_if.slave bus
);
    localparam int LOG_N = $clog2(N);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    logic         s1_valid_q;
    logic [2:0]   s1_op_q;
    logic [N-1:0] s1_a_q;
    logic [N-1:0] s1_b_q;

    logic         s2_valid_q;
    logic [N-1:0] res_q;
    logic         zero_q;
    logic         neg_q;
    logic         carry_q;

    logic s2_adv;
    logic s1_adv;
    logic in_ready_w;
    logic accept;

    // in_ready is combinationally tied to out_ready so a full pipe can still stream.
    assign s2_adv     = !s2_valid_q || bus.out_ready;
    assign s1_adv     = s1_valid_q && s2_adv;
    assign in_ready_w = (!s1_valid_q || s2_adv) && !rst;
    assign accept     = bus.in_valid && in_ready_w;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_res   = res_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_neg   = neg_q;
    assign bus.out_carry = carry_q;

    // Add/sub unit: subtraction is a + ~b + 1, so bit N is the no-borrow flag.
    logic         is_sub;
    logic [N-1:0] addend;
    logic [N:0]   sum;

    assign is_sub = (s1_op_q == OP_SUB);
    assign addend = is_sub ? ~s1_b_q : s1_b_q;
    assign sum    = {1'b0, s1_a_q} + {1'b0, addend} + {{N{1'b0}}, is_sub};

    logic [N-1:0] and_res;
    logic [N-1:0] or_res;
    logic [N-1:0] xor_res;

    for (genvar gi = 0; gi < N; gi++) begin : g_logic_bit
        assign and_res[gi] = s1_a_q[gi] & s1_b_q[gi];
        assign or_res[gi]  = s1_a_q[gi] | s1_b_q[gi];
        assign xor_res[gi] = s1_a_q[gi] ^ s1_b_q[gi];
    end

    // Any set bit above the amount field forces every shift result to zero, SRA included.
    logic [LOG_N-1:0] shamt;
    logic             shift_oor;
    logic [N-1:0]     sll_res;
    logic [N-1:0]     srl_res;
    logic [N-1:0]     sra_res;

    assign shamt     = s1_b_q[LOG_N-1:0];
    assign shift_oor = |s1_b_q[N-1:LOG_N];
    assign sll_res   = shift_oor ? '0 : (s1_a_q << shamt);
    assign srl_res   = shift_oor ? '0 : (s1_a_q >> shamt);
    assign sra_res   = shift_oor ? '0 : N'($signed(s1_a_q) >>> shamt);

    logic [N-1:0] res_d;
    logic         carry_d;
    logic         zero_d;
    logic         neg_d;

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                res_d   = sum[N-1:0];
                carry_d = sum[N];
            end
            OP_SUB: begin
                res_d   = sum[N-1:0];
                carry_d = sum[N];
            end
            OP_AND:  res_d = and_res;
            OP_OR:   res_d = or_res;
            OP_XOR:  res_d = xor_res;
            OP_SLL:  res_d = sll_res;
            OP_SRL:  res_d = srl_res;
            OP_SRA:  res_d = sra_res;
            default: res_d = '0;
        endcase
        zero_d = (res_d == '0);
        neg_d  = res_d[N-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_op_q    <= bus.in_op;
            s1_a_q     <= bus.in_a;
            s1_b_q     <= bus.in_b;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Outputs hold bit-stable whenever stage 2 neither loads nor drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q <= 1'b1;
            res_q      <= res_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            carry_q    <= carry_d;
        end else if (s2_valid_q && bus.out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed and random checks of alu_exec_pipe against a behavioural model,
// using an in-order scoreboard of expected results.
module tb_alu_exec_pipe;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_pipe_if #(.N(N)) bus ();
    alu_exec_pipe #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [N-1:0] res;
        logic         zero;
        logic         neg;
        logic         carry;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   ia, ib, sa, r;
        ia = int'(a);
        ib = int'(b);
        sa = a[N-1] ? ia - (1 << N) : ia;
        r = 0;
        e.carry = 1'b0;
        case (op)
            3'd0: begin r = ia + ib; e.carry = (r >= (1 << N)); end
            3'd1: begin r = ia - ib; e.carry = (ia >= ib); end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = (ib >= N) ? 0 : (ia << ib);
            3'd6: r = (ib >= N) ? 0 : (ia >> ib);
            default: r = (ib >= N) ? 0 : (sa >>> ib);
        endcase
        e.res  = N'(r);
        e.zero = (e.res == '0);
        e.neg  = e.res[N-1];
        e.cyc  = 0;
        return e;
    endfunction

    // One clock: sample handshakes before the edge, score outputs, then step to the next negedge.
    task automatic cycle(output bit acc);
        bit   cons;
        exp_t e;
        #1;
        acc  = bus.in_valid && bus.in_ready;
        cons = bus.out_valid && bus.out_ready;
        if (cons) begin
            ncmp++;
            assert (q.size() > 0) else begin
                nfail++;
                $error("FAIL unexpected_out observed=0x%0h expected=no result", bus.out_res);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                $display("out cyc=%0d res=0x%0h z=%0b n=%0b c=%0b", cyc, bus.out_res, bus.out_zero,
                         bus.out_neg, bus.out_carry);
                chk("res", 32'(bus.out_res), 32'(e.res));
                chk("zero", 32'(bus.out_zero), 32'(e.zero));
                chk("neg", 32'(bus.out_neg), 32'(e.neg));
                chk("carry", 32'(bus.out_carry), 32'(e.carry));
                if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
        if (acc) begin
            e = model(bus.in_op, bus.in_a, bus.in_b);
            e.cyc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        bit acc;
        int n;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            cycle(acc);
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(output int n);
        bit acc;
        bus.in_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            cycle(acc);
            n++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        bit acc;
        int n;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_res", 32'(bus.out_res), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        send(3'd7, 8'h90, 8'h02); drain(n);
        send(3'd7, 8'h90, 8'h08); drain(n);
        send(3'd6, 8'h81, 8'h07); drain(n);
        send(3'd5, 8'h81, 8'h01); drain(n);
        send(3'd0, 8'hFF, 8'h01); drain(n);
        send(3'd1, 8'h05, 8'h07); drain(n);
        send(3'd1, 8'h07, 8'h05); drain(n);
        send(3'd2, 8'hC3, 8'h5A); drain(n);
        send(3'd3, 8'h10, 8'h01); drain(n);
        send(3'd7, 8'h40, 8'h07); drain(n);

        // Backpressure: two ops fill the pipe, the third waits until stage 2 drains.
        lat_chk = 1'b0;
        bus.out_ready = 1'b0;
        send(3'd4, 8'h0F, 8'hFF);
        send(3'd4, 8'h3C, 8'h0F);
        bus.in_op = 3'd4;
        bus.in_a  = 8'hAA;
        bus.in_b  = 8'h55;
        #1;
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_res", 32'(bus.out_res), 32'hF0);
        cycle(acc);
        chk("bp_stall_no_accept", 32'(acc), 32'd0);
        chk("bp_hold_res2", 32'(bus.out_res), 32'hF0);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_fanthru", 32'(bus.in_ready), 32'd1);
        cycle(acc);
        chk("bp_third_accept", 32'(acc), 32'd1);
        drain(n);
        chk("bp_drain_cycles", 32'(n), 32'd2);
        lat_chk = 1'b1;

        for (int i = 0; i < 16; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8)));
        end
        drain(n);
        chk("stream_tail_cycles", 32'(n), 32'd2);

        // Reset with both stages occupied discards everything in flight.
        bus.out_ready = 1'b0;
        send(3'd1, 8'h05, 8'h07);
        send(3'd0, 8'hFF, 8'h01);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_res", 32'(bus.out_res), 32'd0);
        chk("mid_rst_neg", 32'(bus.out_neg), 32'd0);
        chk("mid_rst_flags", 32'({bus.out_zero, bus.out_carry}), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        send(3'd0, 8'h01, 8'h02);
        drain(n);
        for (int i = 0; i < 3; i++) cycle(acc);
        chk("post_rst_idle_valid", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
